// File: rtl/latency_meas.sv
// -----------------------------------------------------------------------------
// latency_meas
//
// Measures per-transaction latency of an in-order request/response path.
// Every accepted request pushes the current timer value into a small FIFO;
// every response pops the oldest entry. The difference (modulo 2**TW) is the
// transaction latency. The block accumulates min/max/saturating-sum and a
// saturating count of completed transactions.
//
// Ports
//   clk              clock
//   rstn             synchronous active-low reset
//   start_i          pulse: clear stats/timer/FIFO/errors, enter RUN
//   stop_i           pulse: stop accepting requests, drain outstanding
//   req_fire_i       a request was accepted this cycle
//   rsp_fire_i       the oldest outstanding request completed this cycle
//   busy_o           high in RUN or DRAIN
//   done_o           high in DONE (statistics final)
//   outstanding_o    current FIFO occupancy
//   lat_last_o       latency of the most recent completed transaction
//   lat_last_vld_o   one-cycle pulse when lat_last_o updates
//   lat_min_o        minimum latency since start (all ones when none yet)
//   lat_max_o        maximum latency since start
//   lat_sum_o        saturating sum of latencies
//   lat_cnt_o        saturating count of completed transactions
//   err_ovf_o        sticky: request arrived while FIFO full (dropped)
//   err_udf_o        sticky: response arrived while FIFO empty (ignored)
// -----------------------------------------------------------------------------
module latency_meas #(
    parameter int TW = 32,
    parameter int AW = 4,
    parameter int CW = 32,
    parameter int SW = 48
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          req_fire_i,
    input  logic          rsp_fire_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW:0]   outstanding_o,
    output logic [TW-1:0] lat_last_o,
    output logic          lat_last_vld_o,
    output logic [TW-1:0] lat_min_o,
    output logic [TW-1:0] lat_max_o,
    output logic [SW-1:0] lat_sum_o,
    output logic [CW-1:0] lat_cnt_o,
    output logic          err_ovf_o,
    output logic          err_udf_o
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0] ts_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [TW-1:0] timer_q;

    logic          busy_q, done_q;
    logic [TW-1:0] lat_last_q;
    logic          lat_last_vld_q;
    logic [TW-1:0] lat_min_q, lat_max_q;
    logic [SW-1:0] lat_sum_q, lat_sum_d;
    logic [CW-1:0] lat_cnt_q;
    logic          err_ovf_q, err_udf_q;

    logic          active, push_req, pop_req, empty, full;
    logic          push, pop, ovf, udf;
    logic [TW-1:0] lat;
    logic [SW:0]   sum_ext;

    // Next-state and datapath decode. start_i suppresses all FIFO activity
    // in its cycle, since the whole block is being cleared anyway.
    always_comb begin
        state_d  = state_q;
        active   = (state_q == S_RUN) || (state_q == S_DRAIN);
        push_req = (state_q == S_RUN) && req_fire_i && !start_i;
        pop_req  = active && rsp_fire_i && !start_i;
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        pop      = pop_req && !empty;
        udf      = pop_req && empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push     = push_req && (!full || pop);
        ovf      = push_req && full && !pop;
        lat      = timer_q - ts_mem[rd_ptr_q];
        sum_ext  = {1'b0, lat_sum_q} + (SW+1)'(lat);
        lat_sum_d = sum_ext[SW] ? '1 : sum_ext[SW-1:0];

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end

        // Completion decisions use the post-update occupancy so that the last
        // response (or a stop with nothing in flight) reaches DONE next cycle.
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (start_i)          state_d = S_RUN;
                else if (stop_i)      state_d = (count_d == '0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (start_i)          state_d = S_RUN;
                else if (count_d == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (start_i) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // busy/done are registered decodes of the state being entered, so they
    // line up with state_q.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q <= (state_d == S_DONE);
        end
    end

    // Timestamp storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr_q] <= timer_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || start_i) begin
            timer_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            lat_last_q     <= '0;
            lat_last_vld_q <= 1'b0;
            lat_min_q      <= '1;
            lat_max_q      <= '0;
            lat_sum_q      <= '0;
            lat_cnt_q      <= '0;
            err_ovf_q      <= 1'b0;
            err_udf_q      <= 1'b0;
        end else begin
            if (active) begin
                timer_q <= timer_q + TW'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q        <= count_d;
            lat_last_vld_q <= pop;
            if (pop) begin
                lat_last_q <= lat;
                lat_sum_q  <= lat_sum_d;
                if (lat < lat_min_q) lat_min_q <= lat;
                if (lat > lat_max_q) lat_max_q <= lat;
                if (lat_cnt_q != '1) lat_cnt_q <= lat_cnt_q + CW'(1);
            end
            if (ovf) err_ovf_q <= 1'b1;
            if (udf) err_udf_q <= 1'b1;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign outstanding_o  = count_q;
    assign lat_last_o     = lat_last_q;
    assign lat_last_vld_o = lat_last_vld_q;
    assign lat_min_o      = lat_min_q;
    assign lat_max_o      = lat_max_q;
    assign lat_sum_o      = lat_sum_q;
    assign lat_cnt_o      = lat_cnt_q;
    assign err_ovf_o      = err_ovf_q;
    assign err_udf_o      = err_udf_q;

endmodule

// File: tb/tb_latency_meas.sv
// -----------------------------------------------------------------------------
// tb_latency_meas
//
// Bench for latency_meas built with small parameters (TW=4, AW=2, CW=6, SW=7)
// so that timer wrap, FIFO full and both saturations are reachable quickly.
// Directed tasks check fixed expected values; the random task compares every
// output each cycle against a transaction-level reference model (queue of
// request cycle numbers, latency = elapsed cycles modulo 2**TW).
// -----------------------------------------------------------------------------
module tb_latency_meas;

    localparam int TW = 4;
    localparam int AW = 2;
    localparam int CW = 6;
    localparam int SW = 7;
    localparam int DEPTH  = 4;
    localparam int TMOD   = 16;
    localparam int SUMMAX = 127;
    localparam int CNTMAX = 63;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0, stop_i = 1'b0, req_fire_i = 1'b0, rsp_fire_i = 1'b0;
    logic          busy_o, done_o;
    logic [AW:0]   outstanding_o;
    logic [TW-1:0] lat_last_o;
    logic          lat_last_vld_o;
    logic [TW-1:0] lat_min_o, lat_max_o;
    logic [SW-1:0] lat_sum_o;
    logic [CW-1:0] lat_cnt_o;
    logic          err_ovf_o, err_udf_o;

    int checks = 0;
    int failures = 0;
    int txn_no = 0;

    latency_meas #(.TW(TW), .AW(AW), .CW(CW), .SW(SW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .req_fire_i     (req_fire_i),
        .rsp_fire_i     (rsp_fire_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .outstanding_o  (outstanding_o),
        .lat_last_o     (lat_last_o),
        .lat_last_vld_o (lat_last_vld_o),
        .lat_min_o      (lat_min_o),
        .lat_max_o      (lat_max_o),
        .lat_sum_o      (lat_sum_o),
        .lat_cnt_o      (lat_cnt_o),
        .err_ovf_o      (err_ovf_o),
        .err_udf_o      (err_udf_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_t;
    mphase_t m_ph;
    int m_now;       // cycles spent measuring since start
    int m_q[$];      // request cycle numbers, oldest first
    int m_last, m_min, m_max, m_sum, m_cnt;
    bit m_vld, m_ovf, m_udf;

    function automatic void model_clear();
        m_now = 0; m_q.delete();
        m_last = 0; m_min = TMOD - 1; m_max = 0; m_sum = 0; m_cnt = 0;
        m_vld = 0; m_ovf = 0; m_udf = 0;
    endfunction

    function automatic void model_step(bit rn, bit s, bit p, bit rq, bit rs);
        bit popped;
        int l;
        if (!rn) begin
            model_clear();
            m_ph = M_IDLE;
            return;
        end
        if (s) begin
            model_clear();
            m_ph = M_RUN;
            return;
        end
        m_vld = 0;
        popped = 0;
        if ((m_ph == M_RUN || m_ph == M_DRAIN) && rs) begin
            if (m_q.size() == 0) begin
                m_udf = 1;
            end else begin
                l = (m_now - m_q.pop_front()) % TMOD;
                popped = 1;
                m_vld = 1; m_last = l;
                if (l < m_min) m_min = l;
                if (l > m_max) m_max = l;
                m_sum = (m_sum + l > SUMMAX) ? SUMMAX : m_sum + l;
                if (m_cnt < CNTMAX) m_cnt++;
            end
        end
        if (m_ph == M_RUN && rq) begin
            if (m_q.size() == DEPTH) m_ovf = 1;
            else m_q.push_back(m_now);
        end
        if (m_ph == M_RUN || m_ph == M_DRAIN) m_now++;
        if (m_ph == M_RUN && p)          m_ph = (m_q.size() == 0) ? M_DONE : M_DRAIN;
        else if (m_ph == M_DRAIN && m_q.size() == 0) m_ph = M_DONE;
        if (popped) txn_no++;
    endfunction

    // One clock: drive inputs, advance model on the edge, sample 1 ns later.
    task automatic tick(input bit s, input bit p, input bit rq, input bit rs);
        start_i = s; stop_i = p; req_fire_i = rq; rsp_fire_i = rs;
        @(posedge clk);
        model_step(rstn, s, p, rq, rs);
        #1;
        if (lat_last_vld_o === 1'b1)
            $display("txn %0d: lat=%0d cnt=%0d min=%0d max=%0d sum=%0d",
                     txn_no, lat_last_o, lat_cnt_o, lat_min_o, lat_max_o, lat_sum_o);
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        rstn = 1'b1;
        checks++; if ({busy_o, done_o} !== 2'b00) begin failures++; $display("FAIL reset.busy_done got=%b exp=00", {busy_o, done_o}); end
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL reset.outstanding got=%0d exp=0", outstanding_o); end
        checks++; if ({lat_last_o, lat_last_vld_o} !== 5'd0) begin failures++; $display("FAIL reset.last got=%0d/%b exp=0/0", lat_last_o, lat_last_vld_o); end
        checks++; if (lat_min_o !== 4'hF || lat_max_o !== 4'h0) begin failures++; $display("FAIL reset.minmax got=%0d/%0d exp=15/0", lat_min_o, lat_max_o); end
        checks++; if (lat_sum_o !== 7'd0 || lat_cnt_o !== 6'd0) begin failures++; $display("FAIL reset.sumcnt got=%0d/%0d exp=0/0", lat_sum_o, lat_cnt_o); end
        checks++; if ({err_ovf_o, err_udf_o} !== 2'b00) begin failures++; $display("FAIL reset.err got=%b exp=00", {err_ovf_o, err_udf_o}); end
        // Traffic in IDLE is ignored entirely.
        tick(0, 0, 1, 1);
        checks++; if (outstanding_o !== 3'd0 || err_udf_o !== 1'b0) begin failures++; $display("FAIL idle.ignore got=%0d/%b exp=0/0", outstanding_o, err_udf_o); end
    endtask

    task automatic test_single();
        tick(1, 0, 0, 0);
        checks++; if ({busy_o, done_o} !== 2'b10) begin failures++; $display("FAIL single.busy got=%b exp=10", {busy_o, done_o}); end
        tick(0, 0, 1, 0);                       // timer 0
        for (int i = 1; i < 5; i++) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);                       // timer 5
        checks++; if (lat_last_o !== 4'd5 || lat_last_vld_o !== 1'b1) begin failures++; $display("FAIL single.last got=%0d/%b exp=5/1", lat_last_o, lat_last_vld_o); end
        checks++; if (lat_min_o !== 4'd5 || lat_max_o !== 4'd5) begin failures++; $display("FAIL single.minmax got=%0d/%0d exp=5/5", lat_min_o, lat_max_o); end
        checks++; if (lat_sum_o !== 7'd5 || lat_cnt_o !== 6'd1) begin failures++; $display("FAIL single.sumcnt got=%0d/%0d exp=5/1", lat_sum_o, lat_cnt_o); end
        tick(0, 0, 0, 0);
        checks++; if (lat_last_vld_o !== 1'b0) begin failures++; $display("FAIL single.vld_pulse got=%b exp=0", lat_last_vld_o); end
    endtask

    // Requests at cycles 0..3; in-order responses at 4,8,10,13 -> 4,7,8,10.
    task automatic test_back_to_back();
        tick(1, 0, 0, 0);
        for (int c = 0; c < 14; c++) begin
            tick(0, 0, c < 4, (c == 4) || (c == 8) || (c == 10) || (c == 13));
            if (c == 3) begin
                checks++; if (outstanding_o !== 3'd4) begin failures++; $display("FAIL b2b.peak got=%0d exp=4", outstanding_o); end
            end
        end
        checks++; if (lat_min_o !== 4'd4 || lat_max_o !== 4'd10) begin failures++; $display("FAIL b2b.minmax got=%0d/%0d exp=4/10", lat_min_o, lat_max_o); end
        checks++; if (lat_sum_o !== 7'd29 || lat_cnt_o !== 6'd4) begin failures++; $display("FAIL b2b.sumcnt got=%0d/%0d exp=29/4", lat_sum_o, lat_cnt_o); end
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL b2b.empty got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_overflow();
        tick(1, 0, 0, 0);
        for (int c = 0; c < 5; c++) tick(0, 0, 1, 0);     // 5th one is dropped
        checks++; if (outstanding_o !== 3'd4 || err_ovf_o !== 1'b1) begin failures++; $display("FAIL ovf.full got=%0d/%b exp=4/1", outstanding_o, err_ovf_o); end
        tick(0, 0, 1, 1);                                 // cycle 5: pop ts0, push
        checks++; if (outstanding_o !== 3'd4 || lat_last_o !== 4'd5) begin failures++; $display("FAIL ovf.pushpop got=%0d/%0d exp=4/5", outstanding_o, lat_last_o); end
        for (int c = 6; c < 10; c++) tick(0, 0, 0, 1);
        checks++; if (outstanding_o !== 3'd0 || err_udf_o !== 1'b0) begin failures++; $display("FAIL ovf.drain got=%0d/%b exp=0/0", outstanding_o, err_udf_o); end
        checks++; if (lat_cnt_o !== 6'd5 || lat_sum_o !== 7'd24) begin failures++; $display("FAIL ovf.sumcnt got=%0d/%0d exp=5/24", lat_cnt_o, lat_sum_o); end
        checks++; if (lat_min_o !== 4'd4 || lat_max_o !== 4'd5 || lat_last_o !== 4'd4) begin failures++; $display("FAIL ovf.stats got=%0d/%0d/%0d exp=4/5/4", lat_min_o, lat_max_o, lat_last_o); end
    endtask

    task automatic test_underflow();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        checks++; if (err_udf_o !== 1'b1 || lat_cnt_o !== 6'd0 || lat_last_vld_o !== 1'b0) begin failures++; $display("FAIL udf.flag got=%b/%0d/%b exp=1/0/0", err_udf_o, lat_cnt_o, lat_last_vld_o); end
        tick(0, 0, 1, 1);
        checks++; if (outstanding_o !== 3'd1 || lat_cnt_o !== 6'd0) begin failures++; $display("FAIL udf.push got=%0d/%0d exp=1/0", outstanding_o, lat_cnt_o); end
        tick(1, 0, 0, 0);
        checks++; if (err_udf_o !== 1'b0 || outstanding_o !== 3'd0) begin failures++; $display("FAIL udf.clear got=%b/%0d exp=0/0", err_udf_o, outstanding_o); end
    endtask

    task automatic test_drain();
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 1, 0, 0);
        checks++; if ({busy_o, done_o} !== 2'b10 || outstanding_o !== 3'd2) begin failures++; $display("FAIL drain.enter got=%b/%0d exp=10/2", {busy_o, done_o}, outstanding_o); end
        tick(0, 0, 1, 0);                                 // ignored in DRAIN
        checks++; if (outstanding_o !== 3'd2) begin failures++; $display("FAIL drain.req_ignored got=%0d exp=2", outstanding_o); end
        tick(0, 0, 0, 1);
        checks++; if ({busy_o, done_o} !== 2'b10) begin failures++; $display("FAIL drain.mid got=%b exp=10", {busy_o, done_o}); end
        tick(0, 0, 0, 1);
        checks++; if ({busy_o, done_o} !== 2'b01 || outstanding_o !== 3'd0) begin failures++; $display("FAIL drain.done got=%b/%0d exp=01/0", {busy_o, done_o}, outstanding_o); end
        checks++; if (lat_cnt_o !== 6'd2 || lat_sum_o !== 7'd8 || lat_last_o !== 4'd4) begin failures++; $display("FAIL drain.stats got=%0d/%0d/%0d exp=2/8/4", lat_cnt_o, lat_sum_o, lat_last_o); end
        tick(0, 0, 0, 1);                                 // ignored in DONE
        checks++; if (lat_cnt_o !== 6'd2 || err_udf_o !== 1'b0) begin failures++; $display("FAIL done.rsp_ignored got=%0d/%b exp=2/0", lat_cnt_o, err_udf_o); end
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);                                 // nothing in flight
        checks++; if ({busy_o, done_o} !== 2'b01) begin failures++; $display("FAIL drain.empty_stop got=%b exp=01", {busy_o, done_o}); end
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);                                 // start beats stop
        tick(0, 0, 1, 0);
        checks++; if ({busy_o, done_o} !== 2'b10 || outstanding_o !== 3'd1) begin failures++; $display("FAIL start_wins got=%b/%0d exp=10/1", {busy_o, done_o}, outstanding_o); end
    endtask

    task automatic test_reset_midrun();
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 1);
        checks++; if (outstanding_o !== 3'd3 || lat_cnt_o !== 6'd1) begin failures++; $display("FAIL midrun.pre got=%0d/%0d exp=3/1", outstanding_o, lat_cnt_o); end
        rstn = 1'b0;
        tick(0, 0, 1, 1);
        rstn = 1'b1;
        checks++; if ({busy_o, done_o, outstanding_o} !== 5'd0 || lat_last_o !== 4'd0 || lat_last_vld_o !== 1'b0) begin failures++; $display("FAIL midrun.ctl got=%b%b/%0d/%0d exp=00/0/0", busy_o, done_o, outstanding_o, lat_last_o); end
        checks++; if (lat_min_o !== 4'hF || lat_max_o !== 4'd0 || lat_sum_o !== 7'd0 || lat_cnt_o !== 6'd0) begin failures++; $display("FAIL midrun.stats got=%0d/%0d/%0d/%0d exp=15/0/0/0", lat_min_o, lat_max_o, lat_sum_o, lat_cnt_o); end
    endtask

    task automatic test_wrap();
        tick(1, 0, 0, 0);
        for (int c = 0; c < 14; c++) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);                                 // timer 14
        for (int c = 15; c < 19; c++) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);                                 // timer 3 after wrap
        checks++; if (lat_last_o !== 4'd5 || lat_cnt_o !== 6'd1) begin failures++; $display("FAIL wrap.lat got=%0d/%0d exp=5/1", lat_last_o, lat_cnt_o); end
    endtask

    task automatic test_saturate();
        tick(1, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin                 // nine latencies of 15
            tick(0, 0, 1, 0);
            for (int c = 0; c < 14; c++) tick(0, 0, 0, 0);
            tick(0, 0, 0, 1);
        end
        checks++; if (lat_sum_o !== 7'd127 || lat_cnt_o !== 6'd9 || lat_max_o !== 4'd15) begin failures++; $display("FAIL sat.sum got=%0d/%0d/%0d exp=127/9/15", lat_sum_o, lat_cnt_o, lat_max_o); end
        for (int k = 0; k < 60; k++) begin                // latency 1 each
            tick(0, 0, 1, 0);
            tick(0, 0, 0, 1);
        end
        checks++; if (lat_cnt_o !== 6'd63 || lat_min_o !== 4'd1 || lat_sum_o !== 7'd127) begin failures++; $display("FAIL sat.cnt got=%0d/%0d/%0d exp=63/1/127", lat_cnt_o, lat_min_o, lat_sum_o); end
    endtask

    // ---------------- randomized test against the model ----------------
    task automatic test_random();
        bit s, p, rq, rs;
        int shown = 0;
        for (int n = 0; n < 4000; n++) begin
            rstn = ($urandom_range(0, 999) != 0);
            if (m_ph == M_IDLE || m_ph == M_DONE) s = ($urandom_range(0, 19) == 0);
            else                                  s = ($urandom_range(0, 399) == 0);
            p  = ($urandom_range(0, 119) == 0);
            rq = ($urandom_range(0, 99) < 45);
            rs = (m_q.size() > 0) ? ($urandom_range(0, 99) < 42) : ($urandom_range(0, 99) < 3);
            tick(s, p, rq, rs);
            checks++;
            if (busy_o !== (m_ph == M_RUN || m_ph == M_DRAIN) || done_o !== (m_ph == M_DONE)
                || outstanding_o !== (AW+1)'(m_q.size()) || lat_last_vld_o !== m_vld
                || lat_last_o !== TW'(m_last) || lat_min_o !== TW'(m_min) || lat_max_o !== TW'(m_max)
                || lat_sum_o !== SW'(m_sum) || lat_cnt_o !== CW'(m_cnt)
                || err_ovf_o !== m_ovf || err_udf_o !== m_udf) begin
                failures++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random.cycle%0d got b%b d%b o%0d v%b l%0d mn%0d mx%0d s%0d c%0d e%b%b exp b%b d%b o%0d v%b l%0d mn%0d mx%0d s%0d c%0d e%b%b",
                             n, busy_o, done_o, outstanding_o, lat_last_vld_o, lat_last_o, lat_min_o, lat_max_o,
                             lat_sum_o, lat_cnt_o, err_ovf_o, err_udf_o,
                             (m_ph == M_RUN || m_ph == M_DRAIN), (m_ph == M_DONE), m_q.size(), m_vld, m_last,
                             m_min, m_max, m_sum, m_cnt, m_ovf, m_udf);
                end
            end
        end
        rstn = 1'b1;
    endtask

    initial begin
        m_ph = M_IDLE;
        model_clear();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_drain();
        test_reset_midrun();
        test_wrap();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
